// File: rtl/main_memory_pkg.sv
// Shared definitions for the block-transfer main memory: FSM encoding and
// helpers that derive block geometry from the top-level parameters.
package main_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int DEFAULT_ADDR_WIDTH      = 10;
    localparam int DEFAULT_WORD_WIDTH      = 32;
    localparam int DEFAULT_WORDS_PER_BLOCK = 4;
    localparam int DEFAULT_LATENCY         = 4;

    function automatic int calc_block_bytes(input int word_width, input int words_per_block);
        return (words_per_block * word_width) / 8;
    endfunction

    function automatic int calc_offset_bits(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int calc_count_width(input int latency);
        return $clog2(latency + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Geometry of the default build, for users that do not override parameters.
    localparam int BLOCK_BYTES = calc_block_bytes(DEFAULT_WORD_WIDTH, DEFAULT_WORDS_PER_BLOCK);
    localparam int OFFSET_BITS = calc_offset_bits(BLOCK_BYTES);
    localparam int COUNT_WIDTH = calc_count_width(DEFAULT_LATENCY);

endpackage

// File: rtl/main_memory_block_byte_array.sv
// Byte-organised storage with a block-wide write port and a block-wide
// registered read port; i_addr is always block-aligned.
module memory_byte_array
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_we,
    input  logic                       i_re,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [8*BLOCK_BYTES-1:0]   i_wdata,
    output logic [8*BLOCK_BYTES-1:0]   o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]               r_mem [DEPTH] = '{default: 8'h00};
    logic [8*BLOCK_BYTES-1:0] r_rdata;

    // Block write: byte b of the block lands at aligned address + b.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                r_mem[i_addr | ADDR_WIDTH'(b)] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Registered block read; reset clears the output register only.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rdata <= {(8*BLOCK_BYTES){1'b0}};
        end else if (i_re) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                r_rdata[8*b +: 8] <= r_mem[i_addr | ADDR_WIDTH'(b)];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory_block.sv
// Clocked main memory serving whole cache lines over a level-request /
// one-cycle done handshake with a programmable access latency.
module main_memory_block
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int WORD_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  read,
    input  logic                                  write,
    input  logic [ADDR_WIDTH-1:0]                 address,
    input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] write_data,
    output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] read_data,
    output logic                                  busy,
    output logic                                  done
);

    localparam int BLOCK_BITS     = WORD_WIDTH * WORDS_PER_BLOCK;
    localparam int BLK_BYTES      = calc_block_bytes(WORD_WIDTH, WORDS_PER_BLOCK);
    localparam int BLK_OFFSET     = calc_offset_bits(BLK_BYTES);
    localparam int CNT_WIDTH      = calc_count_width(LATENCY);
    localparam logic [CNT_WIDTH-1:0]  COUNT_LOAD  = CNT_WIDTH'(LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0]  COUNT_LAST  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(BLK_BYTES - 1);

    if ((WORD_WIDTH % 8) != 0) begin : g_chk_word
        $error("WORD_WIDTH must be a multiple of 8");
    end
    if (!is_pow2(WORDS_PER_BLOCK)) begin : g_chk_wpb
        $error("WORDS_PER_BLOCK must be a power of two");
    end
    if (LATENCY < 1) begin : g_chk_lat
        $error("LATENCY must be at least 1");
    end
    if (ADDR_WIDTH <= BLK_OFFSET) begin : g_chk_addr
        $error("ADDR_WIDTH must exceed the block offset width");
    end

    state_e                  r_state;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_is_write;
    logic [BLOCK_BITS-1:0]   r_wdata;
    logic                    r_busy;
    logic                    r_done;

    state_e                  w_next_state;
    logic                    w_accept;
    logic                    w_req_write;
    logic                    w_from_idle;
    logic                    w_enter_resp;
    logic                    w_op_write;
    logic                    w_mem_we;
    logic                    w_mem_re;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [BLOCK_BITS-1:0]   w_mem_wdata;

    // Next-state and memory-port control; with LATENCY=1 the array is
    // accessed on the accepting edge, so the port takes the live inputs.
    always_comb begin
        w_next_state = ST_IDLE;
        w_req_write  = write && !read;
        w_from_idle  = (r_state == ST_IDLE);
        w_accept     = w_from_idle && (read || write) && !reset;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_count == COUNT_LAST) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);
        w_op_write   = w_from_idle ? w_req_write : r_is_write;
        w_mem_we     = w_enter_resp && w_op_write;
        w_mem_re     = w_enter_resp && !w_op_write;
        w_mem_addr   = w_from_idle ? (address & ALIGN_MASK) : r_addr;
        w_mem_wdata  = w_from_idle ? write_data : r_wdata;
    end

    // FSM, latency counter and request latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= {CNT_WIDTH{1'b0}};
            r_addr     <= {ADDR_WIDTH{1'b0}};
            r_is_write <= 1'b0;
            r_wdata    <= {BLOCK_BITS{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_RESP);
            if (w_accept) begin
                r_addr     <= address & ALIGN_MASK;
                r_is_write <= w_req_write;
                r_count    <= COUNT_LOAD;
                if (w_req_write) begin
                    r_wdata <= write_data;
                end
            end else if (r_state == ST_ACCESS) begin
                r_count <= r_count - COUNT_LAST;
            end
        end
    end

    memory_byte_array #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BLOCK_BYTES (BLK_BYTES)
    ) u_array (
        .i_clock (clock),
        .i_reset (reset),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (read_data)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule
